store_narrow_32: RTL and testbench

- Store-side data narrower: the write-direction counterpart of the load path's immediate/data widening.
- Accepts a 32-bit register value, a byte address and an access size from the MEM stage.
- Narrows and replicates the value onto the correct byte lanes, generates byte enables and a word-aligned address, and issues one write on a valid/ready memory port.
- Flags misaligned or illegal accesses, and writes that are not acknowledged within a timeout.

---
 rtl/store_narrow_32_pkg.sv | 14 +
 rtl/store_narrow_32_lane_map.sv | 42 ++++
 rtl/store_narrow_32.sv | 121 ++++++++++++
 tb/tb_store_narrow_32.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/store_narrow_32_pkg.sv
// rtl/store_narrow_32_pkg.sv - shared size codes and FSM encoding for the store narrower
package store_narrow_32_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/store_narrow_32_lane_map.sv
// rtl/store_narrow_32_lane_map.sv - combinational byte-lane replication, enables and alignment check
module store_narrow_32_lane_map
    import store_narrow_32_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        illegal
);

    logic [3:0] be_le;

    always_comb begin
        wdata   = data;
        be_le   = 4'b0000;
        illegal = 1'b0;
        case (size)
            SIZE_BYTE: begin
                wdata = {4{data[7:0]}};
                be_le = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                wdata   = {2{data[15:0]}};
                be_le   = addr_lo[1] ? 4'b1100 : 4'b0011;
                illegal = addr_lo[0];
            end
            SIZE_WORD: begin
                be_le   = 4'b1111;
                illegal = |addr_lo;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Big-endian lane order is the little-endian enable mask mirrored.
    assign be = (BIG_ENDIAN != 0) ? {be_le[0], be_le[1], be_le[2], be_le[3]} : be_le;

endmodule

// File: rtl/store_narrow_32.sv
// rtl/store_narrow_32.sv - store-side narrower issuing one byte-enabled write per request
module store_narrow_32
    import store_narrow_32_pkg::*;
#(
    parameter int BIG_ENDIAN  = 0,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_wr_valid,
    input  logic        mem_wr_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        done,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic [31:0] err_addr
);

    localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] lm_wdata;
    logic [3:0]  lm_be;
    logic        lm_illegal;
    logic        accept;
    logic        acked;
    logic        expired;

    store_narrow_32_lane_map #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_lane_map (
        .addr_lo (req_addr[1:0]),
        .size    (req_size),
        .data    (req_data),
        .wdata   (lm_wdata),
        .be      (lm_be),
        .illegal (lm_illegal)
    );

    assign req_ready = rst_n && (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign acked     = (state == ST_SEND) && mem_wr_ready;
    // A ready on the expiry cycle takes priority over the timeout.
    assign expired   = (state == ST_SEND) && !mem_wr_ready && (cnt == CNT_LAST);

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_be    = (state == ST_SEND) ? be_q : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mem_wr_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = lm_illegal ? ST_ERR : ST_SEND;
                end
            end
            ST_SEND: begin
                mem_wr_valid = 1'b1;
                if (mem_wr_ready || (cnt == CNT_LAST)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= 16'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'b0000;
            done         <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            err_addr     <= 32'd0;
        end else begin
            done         <= acked;
            timeout_err  <= expired;
            misalign_err <= accept && lm_illegal;

            if (accept && !lm_illegal) begin
                addr_q  <= req_addr;
                wdata_q <= lm_wdata;
                be_q    <= lm_be;
                cnt     <= 16'd0;
            end else if ((state == ST_SEND) && !mem_wr_ready) begin
                cnt <= cnt + 16'd1;
            end

            if (accept && lm_illegal) begin
                err_addr <= req_addr;
            end else if (expired) begin
                err_addr <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_store_narrow_32.sv
// tb/tb_store_narrow_32.sv - randomized bench for store_narrow_32 with a transaction-level model
module tb_store_narrow_32;
    import store_narrow_32_pkg::*;

    localparam int TMO  [2] = '{4, 16};
    localparam bit BIGE [2] = '{1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_wr_ready;

    logic        req_ready    [2];
    logic        wr_valid     [2];
    logic [31:0] wr_addr      [2];
    logic [31:0] wr_data      [2];
    logic [3:0]  wr_be        [2];
    logic        done         [2];
    logic        misalign_err [2];
    logic        timeout_err  [2];
    logic [31:0] err_addr     [2];

    logic [31:0] exp_err [2];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    store_narrow_32 #(.BIG_ENDIAN(1), .ACK_TIMEOUT(4)) dut_be (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_wr_valid(wr_valid[0]), .mem_wr_ready(mem_wr_ready),
        .mem_addr(wr_addr[0]), .mem_wdata(wr_data[0]), .mem_be(wr_be[0]),
        .done(done[0]), .misalign_err(misalign_err[0]), .timeout_err(timeout_err[0]),
        .err_addr(err_addr[0])
    );

    store_narrow_32 #(.BIG_ENDIAN(0), .ACK_TIMEOUT(16)) dut_le (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_wr_valid(wr_valid[1]), .mem_wr_ready(mem_wr_ready),
        .mem_addr(wr_addr[1]), .mem_wdata(wr_data[1]), .mem_be(wr_be[1]),
        .done(done[1]), .misalign_err(misalign_err[1]), .timeout_err(timeout_err[1]),
        .err_addr(err_addr[1])
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_illegal(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b11) return 1'b1;
        return (a % (32'd1 << s)) != 32'd0;
    endfunction

    // Every memory byte lane carries byte (lane mod access width) of the value.
    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] s);
        logic [31:0] r;
        int n;
        n = 1 << s;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = d[8*(j % n) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] s, input bit big);
        logic [3:0] r;
        int n, off;
        r = 4'b0000;
        n = 1 << s;
        for (int j = 0; j < n; j++) begin
            off = int'(a % 4) + j;
            r[big ? 3 - off : off] = 1'b1;
        end
        return r;
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input int dly);
        bit          ill, v, ev, to;
        int          last [2];
        int          kmax;
        logic [31:0] ew;
        logic [3:0]  eb [2];
        ill  = m_illegal(a, s);
        ew   = m_wdata(d, s);
        kmax = 0;
        for (int i = 0; i < 2; i++) begin
            last[i] = ill ? -1 : ((dly < TMO[i] - 1) ? dly : TMO[i] - 1);
            eb[i]   = ill ? 4'b0000 : m_be(a, s, BIGE[i]);
            if (last[i] + 2 > kmax) kmax = last[i] + 2;
        end
        req_valid    = 1'b1;
        req_addr     = a;
        req_data     = d;
        req_size     = s;
        mem_wr_ready = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= kmax; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_data  = $urandom;
            req_size  = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                v  = (k <= last[i]);
                ev = (k == last[i] + 1);
                to = !ill && (dly > TMO[i] - 1);
                if (ev && (ill || to)) exp_err[i] = a;
                expect_eq($sformatf("wr_valid%0d k%0d", i, k), 32'(wr_valid[i]), 32'(v));
                expect_eq($sformatf("req_ready%0d k%0d", i, k), 32'(req_ready[i]), 32'(!v && !(ill && k == 0)));
                expect_eq($sformatf("be%0d k%0d", i, k), 32'(wr_be[i]), 32'(v ? eb[i] : 4'b0000));
                if (v) begin
                    expect_eq($sformatf("addr%0d k%0d", i, k), wr_addr[i], {a[31:2], 2'b00});
                    expect_eq($sformatf("wdata%0d k%0d", i, k), wr_data[i], ew);
                end
                expect_eq($sformatf("done%0d k%0d", i, k), 32'(done[i]), 32'(ev && !ill && !to));
                expect_eq($sformatf("timeout%0d k%0d", i, k), 32'(timeout_err[i]), 32'(ev && to));
                expect_eq($sformatf("misalign%0d k%0d", i, k), 32'(misalign_err[i]), 32'(ev && ill));
                expect_eq($sformatf("err_addr%0d k%0d", i, k), err_addr[i], exp_err[i]);
            end
            mem_wr_ready = (k >= dly);
        end
        mem_wr_ready = 1'b0;
    endtask

    task automatic reset_mid_send(input logic [31:0] a);
        req_valid    = 1'b1;
        req_addr     = {a[31:2], 2'b00};
        req_data     = $urandom;
        req_size     = SIZE_WORD;
        mem_wr_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) expect_eq($sformatf("rst_pre_valid%0d", i), 32'(wr_valid[i]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_err[i] = 32'd0;
            expect_eq($sformatf("rst_valid%0d", i), 32'(wr_valid[i]), 32'd0);
            expect_eq($sformatf("rst_ready%0d", i), 32'(req_ready[i]), 32'd0);
            expect_eq($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
            expect_eq($sformatf("rst_timeout%0d", i), 32'(timeout_err[i]), 32'd0);
            expect_eq($sformatf("rst_misalign%0d", i), 32'(misalign_err[i]), 32'd0);
            expect_eq($sformatf("rst_be%0d", i), 32'(wr_be[i]), 32'd0);
            expect_eq($sformatf("rst_addr%0d", i), wr_addr[i], 32'd0);
            expect_eq($sformatf("rst_wdata%0d", i), wr_data[i], 32'd0);
            expect_eq($sformatf("rst_err_addr%0d", i), err_addr[i], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            expect_eq($sformatf("rel_ready%0d", i), 32'(req_ready[i]), 32'd1);
            expect_eq($sformatf("rel_valid%0d", i), 32'(wr_valid[i]), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = 32'd0;
        req_data     = 32'd0;
        req_size     = 2'b00;
        mem_wr_ready = 1'b0;
        exp_err      = '{32'd0, 32'd0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            expect_eq($sformatf("init_ready%0d", i), 32'(req_ready[i]), 32'd0);
            expect_eq($sformatf("init_valid%0d", i), 32'(wr_valid[i]), 32'd0);
            expect_eq($sformatf("init_be%0d", i), 32'(wr_be[i]), 32'd0);
            expect_eq($sformatf("init_addr%0d", i), wr_addr[i], 32'd0);
            expect_eq($sformatf("init_wdata%0d", i), wr_data[i], 32'd0);
            expect_eq($sformatf("init_err_addr%0d", i), err_addr[i], 32'd0);
            expect_eq($sformatf("init_pulses%0d", i),
                      32'({done[i], misalign_err[i], timeout_err[i]}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) expect_eq($sformatf("init_rel_ready%0d", i), 32'(req_ready[i]), 32'd1);

        do_store(32'h0000_1003, 32'hDEAD_BEEF, SIZE_BYTE, 0);
        do_store(32'h0000_2002, 32'h1234_5678, SIZE_HALF, 1);
        do_store(32'h0000_3001, 32'hCAFE_F00D, SIZE_WORD, 0);
        do_store(32'h0000_3001, 32'hCAFE_F00D, 2'b11, 0);
        do_store(32'h0000_4004, 32'hA5A5_5A5A, SIZE_WORD, 10);
        do_store(32'h0000_5000, 32'h0BAD_CAFE, SIZE_WORD, 30);
        do_store(32'h0000_6008, 32'h1357_9BDF, SIZE_WORD, 3);
        do_store(32'h0000_7003, 32'h0000_0042, SIZE_HALF, 0);
        reset_mid_send(32'h0000_8000);
        do_store(32'h0000_9001, 32'h89AB_CDEF, SIZE_BYTE, 2);

        for (int t = 0; t < 60; t++) begin
            a = $urandom;
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && s != 2'b11) a = a & ~((32'd1 << s) - 32'd1);
            do_store(a, $urandom, s, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
